// File: rtl/debounce_pkg.sv
// Shared types and default constants for the debounce/edge-detect stage.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        QUAL_HIGH   = 2'b01,
        STABLE_HIGH = 2'b11,
        QUAL_LOW    = 2'b10
    } state_t;

    localparam int unsigned DEF_STABLE_CYCLES = 4;
    localparam int unsigned DEF_CNT_WIDTH     = 8;

endpackage

// File: rtl/debounce_edge_stable_counter.sv
// Qualification counter: synchronous clear wins over enable, and the flag is
// registered so it reflects the count currently held.
module stable_counter #(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned TERMINAL = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic count_enable,
    output logic rollover_flag
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             rollover_q;
    logic             rollover_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable && (count_q != WIDTH'(TERMINAL))) begin
            count_d = count_q + WIDTH'(1);
        end
        rollover_d = (count_d == WIDTH'(TERMINAL));
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q    <= '0;
            rollover_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            rollover_q <= rollover_d;
        end
    end

    assign rollover_flag = rollover_q;

endmodule

// File: rtl/debounce_edge.sv
// Debounce and edge detection behind the two-flop synchronizer.
// Optional accepted-rise counter is enabled with DEBOUNCE_EVENT_CNT_EN.
module debounce_edge
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
`ifdef DEBOUNCE_EVENT_CNT_EN
    ,
    parameter int unsigned CNT_WIDTH     = DEF_CNT_WIDTH
`endif
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 sync_in,
`ifdef DEBOUNCE_EVENT_CNT_EN
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] event_count,
`endif
    output logic                 clean_out,
    output logic                 rise_pulse,
    output logic                 fall_pulse,
    output logic                 busy
);

    localparam int unsigned QCNT_W = $clog2(STABLE_CYCLES) + 1;

    state_t state_q;
    state_t state_d;
    logic   clean_q, clean_d;
    logic   rise_q, rise_d;
    logic   fall_q, fall_d;
    logic   busy_q, busy_d;
    logic   cnt_clear_c;
    logic   cnt_en_c;
    logic   rollover_c;
    logic   in_high_c;

    // Anything that is not a clean 1 counts as low.
    assign in_high_c = (sync_in == 1'b1);

    stable_counter #(
        .WIDTH    (QCNT_W),
        .TERMINAL (STABLE_CYCLES - 1)
    ) u_qcnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (cnt_clear_c),
        .count_enable  (cnt_en_c),
        .rollover_flag (rollover_c)
    );

    always_comb begin
        state_d     = state_q;
        clean_d     = clean_q;
        rise_d      = 1'b0;
        fall_d      = 1'b0;
        cnt_clear_c = 1'b0;
        cnt_en_c    = 1'b0;
        case (state_q)
            STABLE_LOW: begin
                if (in_high_c) begin
                    state_d  = QUAL_HIGH;
                    cnt_en_c = 1'b1;
                end else begin
                    cnt_clear_c = 1'b1;
                end
            end
            QUAL_HIGH: begin
                if (!in_high_c) begin
                    state_d     = STABLE_LOW;
                    cnt_clear_c = 1'b1;
                end else if (rollover_c) begin
                    state_d     = STABLE_HIGH;
                    clean_d     = 1'b1;
                    rise_d      = 1'b1;
                    cnt_clear_c = 1'b1;
                end else begin
                    cnt_en_c = 1'b1;
                end
            end
            STABLE_HIGH: begin
                if (!in_high_c) begin
                    state_d  = QUAL_LOW;
                    cnt_en_c = 1'b1;
                end else begin
                    cnt_clear_c = 1'b1;
                end
            end
            QUAL_LOW: begin
                if (in_high_c) begin
                    state_d     = STABLE_HIGH;
                    cnt_clear_c = 1'b1;
                end else if (rollover_c) begin
                    state_d     = STABLE_LOW;
                    clean_d     = 1'b0;
                    fall_d      = 1'b1;
                    cnt_clear_c = 1'b1;
                end else begin
                    cnt_en_c = 1'b1;
                end
            end
            default: begin
                state_d     = STABLE_LOW;
                clean_d     = 1'b0;
                cnt_clear_c = 1'b1;
            end
        endcase
        busy_d = (state_d == QUAL_HIGH) || (state_d == QUAL_LOW);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= STABLE_LOW;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign clean_out  = clean_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign busy       = busy_q;

`ifdef DEBOUNCE_EVENT_CNT_EN
    logic [CNT_WIDTH-1:0] event_count_q;
    logic [CNT_WIDTH-1:0] event_count_d;

    // Counts cycles with rise_pulse high; clear takes priority over a rise.
    always_comb begin
        event_count_d = event_count_q;
        if (clear) begin
            event_count_d = '0;
        end else if (rise_q && (event_count_q != {CNT_WIDTH{1'b1}})) begin
            event_count_d = event_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            event_count_q <= '0;
        end else begin
            event_count_q <= event_count_d;
        end
    end

    assign event_count = event_count_q;
`endif

endmodule

// File: tb/tb_debounce_edge.sv
// Self-checking bench for debounce_edge with a run-length reference model.
// Define DEBOUNCE_EVENT_CNT_EN to also exercise the event counter.
module tb_debounce_edge;

    localparam int SC    = 4;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk;
    logic n_rst;
    logic sync_in;
    logic clean_out, rise_pulse, fall_pulse, busy;
`ifdef DEBOUNCE_EVENT_CNT_EN
    logic             clear;
    logic [CNT_W-1:0] event_count;
`endif

    int checks = 0;
    int errors = 0;

    // reference model state
    logic m_clean, m_rise, m_fall, m_busy;
    int   m_run;
    int   m_cnt;

    debounce_edge #(
        .STABLE_CYCLES (SC)
`ifdef DEBOUNCE_EVENT_CNT_EN
        ,
        .CNT_WIDTH     (CNT_W)
`endif
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .sync_in     (sync_in),
`ifdef DEBOUNCE_EVENT_CNT_EN
        .clear       (clear),
        .event_count (event_count),
`endif
        .clean_out   (clean_out),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_clean = 1'b0;
        m_rise  = 1'b0;
        m_fall  = 1'b0;
        m_busy  = 1'b0;
        m_run   = 0;
        m_cnt   = 0;
    endtask

    // A level differing from the accepted one must persist SC samples in a row.
    task automatic model_edge(input logic x, input logic clr);
        if (clr) m_cnt = 0;
        else if (m_rise && m_cnt != CMAX) m_cnt++;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (x != m_clean) begin
            m_run++;
            if (m_run == SC) begin
                m_clean = x;
                m_rise  = x;
                m_fall  = ~x;
                m_run   = 0;
            end
        end else begin
            m_run = 0;
        end
        m_busy = (m_run != 0);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic x, input logic clr);
        sync_in = x;
`ifdef DEBOUNCE_EVENT_CNT_EN
        clear = clr;
`endif
        @(posedge clk);
        model_edge(x, clr);
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_rst   = 1'b0;
        sync_in = 1'b1;
`ifdef DEBOUNCE_EVENT_CNT_EN
        clear = 1'b0;
`endif
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({clean_out, rise_pulse, fall_pulse, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold got %b exp 0000", {clean_out, rise_pulse, fall_pulse, busy});
        end
        n_rst = 1'b1;
        for (int i = 1; i <= SC; i++) begin
            step(1'b1, 1'b0);
            checks++;
            if (busy !== (i < SC) || clean_out !== (i == SC)) begin
                errors++;
                $display("FAIL reset_release edge%0d got busy=%b clean=%b exp busy=%b clean=%b",
                         i, busy, clean_out, (i < SC), (i == SC));
            end
        end
        repeat (SC + 1) step(1'b0, 1'b0);
    endtask

    task automatic test_clean_press();
        int busy_n = 0;
        int rise_n = 0;
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b0);
            busy_n += int'(busy);
            rise_n += int'(rise_pulse);
            checks++;
            if ({clean_out, rise_pulse, fall_pulse, busy} !== {m_clean, m_rise, m_fall, m_busy}) begin
                errors++;
                $display("FAIL press edge%0d got %b exp %b", i,
                         {clean_out, rise_pulse, fall_pulse, busy}, {m_clean, m_rise, m_fall, m_busy});
            end
            if (i == SC) begin
                checks++;
                if (clean_out !== 1'b1 || rise_pulse !== 1'b1) begin
                    errors++;
                    $display("FAIL press_accept got clean=%b rise=%b exp 1 1", clean_out, rise_pulse);
                end
            end
        end
        checks++;
        if (busy_n != SC - 1 || rise_n != 1) begin
            errors++;
            $display("FAIL press_counts got busy=%0d rise=%0d exp busy=%0d rise=1", busy_n, rise_n, SC - 1);
        end
        repeat (SC + 1) step(1'b0, 1'b0);
    endtask

    task automatic test_glitch();
        int pulses = 0;
        for (int i = 0; i < SC - 1; i++) begin
            step(1'b1, 1'b0);
            pulses += int'(rise_pulse) + int'(fall_pulse);
        end
        step(1'b0, 1'b0);
        checks++;
        if (busy !== 1'b0 || clean_out !== 1'b0 || pulses != 0 || rise_pulse !== 1'b0) begin
            errors++;
            $display("FAIL glitch got busy=%b clean=%b pulses=%0d exp 0 0 0", busy, clean_out, pulses);
        end
        // exactly SC cycles is the acceptance threshold
        for (int i = 0; i < SC; i++) step(1'b1, 1'b0);
        checks++;
        if (clean_out !== 1'b1 || rise_pulse !== 1'b1) begin
            errors++;
            $display("FAIL threshold got clean=%b rise=%b exp 1 1", clean_out, rise_pulse);
        end
        repeat (SC + 1) step(1'b0, 1'b0);
    endtask

    task automatic test_bounce();
        logic seq [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        int falls = 0;
        for (int i = 0; i < 6; i++) begin
            step(seq[i], 1'b0);
            checks++;
            if (clean_out !== (i == 5)) begin
                errors++;
                $display("FAIL bounce edge%0d got clean=%b exp %b", i + 1, clean_out, (i == 5));
            end
        end
        for (int i = 0; i < SC; i++) begin
            step(1'b0, 1'b0);
            falls += int'(fall_pulse);
        end
        checks++;
        if (falls != 1 || clean_out !== 1'b0) begin
            errors++;
            $display("FAIL release got falls=%0d clean=%b exp 1 0", falls, clean_out);
        end
        step(1'b0, 1'b0);
    endtask

    task automatic test_mid_reset();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        #2 n_rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({clean_out, rise_pulse, fall_pulse, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset got %b exp 0000", {clean_out, rise_pulse, fall_pulse, busy});
        end
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 1; i <= SC; i++) begin
            step(1'b1, 1'b0);
            checks++;
            if (clean_out !== (i == SC) || busy !== (i < SC)) begin
                errors++;
                $display("FAIL requal edge%0d got clean=%b busy=%b exp %b %b",
                         i, clean_out, busy, (i == SC), (i < SC));
            end
        end
        repeat (SC + 1) step(1'b0, 1'b0);
    endtask

    task automatic test_random();
        int cyc = 0;
        while (cyc < 400) begin
            logic v   = 1'($urandom_range(0, 1));
            int   len = int'($urandom_range(1, SC + 2));
            for (int k = 0; k < len; k++) begin
                step(v, 1'b0);
                cyc++;
                checks++;
                if ({clean_out, rise_pulse, fall_pulse, busy} !== {m_clean, m_rise, m_fall, m_busy}
                    || (rise_pulse && fall_pulse)) begin
                    errors++;
                    $display("FAIL random cyc%0d got %b exp %b", cyc,
                             {clean_out, rise_pulse, fall_pulse, busy}, {m_clean, m_rise, m_fall, m_busy});
                end
            end
        end
        repeat (SC + 1) step(1'b0, 1'b0);
    endtask

`ifdef DEBOUNCE_EVENT_CNT_EN
    task automatic test_event_count();
        @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        model_reset();
        n_rst = 1'b1;
        for (int p = 0; p < 300; p++) begin
            for (int i = 0; i < SC; i++) step(1'b1, 1'b0);
            for (int i = 0; i < SC; i++) step(1'b0, 1'b0);
            if (p == 9 || p == 299) begin
                checks++;
                if (int'(event_count) != m_cnt) begin
                    errors++;
                    $display("FAIL event_count press%0d got %0d exp %0d", p + 1, event_count, m_cnt);
                end
            end
        end
        checks++;
        if (event_count !== 8'd255) begin
            errors++;
            $display("FAIL event_sat got %0d exp 255", event_count);
        end
        for (int i = 0; i < SC; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        checks++;
        if (event_count !== 8'd0) begin
            errors++;
            $display("FAIL clear_wins got %0d exp 0", event_count);
        end
        repeat (SC + 1) step(1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_mid_reset();
        test_random();
`ifdef DEBOUNCE_EVENT_CNT_EN
        test_event_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debounce_edge.md
# debounce_edge

Debounce and edge-detection stage placed directly downstream of the `sync_high` two-flop synchronizer. It consumes the synchronized level and qualifies it: a change must persist for `STABLE_CYCLES` consecutive clocks before it is accepted. It then produces a clean level plus single-cycle rise and fall pulses for the control logic downstream.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples needed to accept a level change. Legal values are ≥ 2.
- `CNT_WIDTH`, default 8: width of the accepted-rise event counter. Only present under `DEBOUNCE_EVENT_CNT_EN`.
- `clk`  input  1: system clock. Every flop uses the rising edge.
- `n_rst`  input  1: reset. Asynchronous, active-low.
- `sync_in`  input  1: synchronized level from `sync_high.sync_out`. Any value other than 1'b1 is treated as 0.
- `clean_out`  output  1: debounced level.
- `rise_pulse`  output  1: one-cycle pulse when `clean_out` goes 0→1.
- `fall_pulse`  output  1: one-cycle pulse when `clean_out` goes 1→0.
- `busy`  output  1: high while a candidate change is being qualified.
- `clear`  input  1: synchronous clear of `event_count`. Only present under the macro.
- `event_count`  output  CNT_WIDTH: saturating count of accepted rises. Only present under the macro.

## Operation
- Four-state FSM: STABLE_LOW, QUAL_HIGH, STABLE_HIGH, QUAL_LOW. The qualification counter `qcnt` has width `$clog2(STABLE_CYCLES)+1`.
- STABLE_LOW:
  - `sync_in`=1 → QUAL_HIGH with `qcnt`=1.
  - Otherwise the FSM stays in STABLE_LOW and `qcnt`=0.
- QUAL_HIGH:
  - `sync_in`=0 → STABLE_LOW with `qcnt`=0. The glitch is rejected and no pulse is produced.
  - `sync_in`=1 and `qcnt`=STABLE_CYCLES-1 → STABLE_HIGH. On this transition `clean_out`←1, `rise_pulse`←1 and `qcnt`←0.
  - Otherwise `qcnt` increments.
- STABLE_HIGH and QUAL_LOW mirror the two rows above with polarity inverted; the accept transition asserts `fall_pulse`.
- A bounce during qualification restarts qualification from the stable state. There is no partial credit.
- `busy` is 1 exactly in QUAL_HIGH and QUAL_LOW.
- `rise_pulse` and `fall_pulse` are never high together. Each is high for exactly one cycle per accepted change.
- Reset mid-operation: all state and outputs return immediately to their reset values, whatever the current state.

## Timing
- All outputs are registered; there are no combinational paths from `sync_in` to outputs.
- Reset values: `clean_out`=0 (matches the synchronizer's inactive value), `rise_pulse`=0, `fall_pulse`=0, `busy`=0, `event_count`=0. The FSM resets to STABLE_LOW with `qcnt`=0.
- Latency: suppose `sync_in` first becomes 1 before rising edge e1 and holds. Then:
  - `busy` is high after e1.
  - `clean_out` and `rise_pulse` go high after edge e_STABLE_CYCLES.
  - `rise_pulse` drops after e_STABLE_CYCLES+1.
- Acceptance threshold: a `sync_in` pulse of exactly STABLE_CYCLES cycles is accepted; a pulse of STABLE_CYCLES-1 cycles is rejected.
- End-to-end latency from the raw asynchronous pin is 2 cycles (synchronizer) + STABLE_CYCLES.
- The bench samples outputs at the falling edge.

## Configuration
- Macro: `DEBOUNCE_EVENT_CNT_EN`.
- When defined:
  - `clear` and `event_count` exist.
  - `event_count` increments on each cycle in which `rise_pulse` is asserted, saturating at 2^CNT_WIDTH-1.
  - If `clear` and an accepted rise occur in the same cycle, clear wins and the result is 0.
- When undefined: both ports and the counter logic are absent. All other behaviour is identical.

## Structure
- `debounce_pkg` holds:
  - the `state_t` enum (STABLE_LOW=2'b00, QUAL_HIGH=2'b01, STABLE_HIGH=2'b11, QUAL_LOW=2'b10);
  - the default constants `DEF_STABLE_CYCLES`=4 and `DEF_CNT_WIDTH`=8.
- One sub-module, `stable_counter`, implements `qcnt`:
  - inputs: `clear`, `count_enable`;
  - parameter: terminal value;
  - output: `rollover_flag`.
- The FSM, pulse registers and optional event counter live in `debounce_edge`.

## Test plan
All scenarios use STABLE_CYCLES=4.

- Reset with `sync_in`=1 held → while `n_rst`=0, `clean_out`=0, `busy`=0 and both pulses are 0. After release, `busy` is 1 after the first edge and `clean_out`=1 after the 4th edge.
- Clean press: `sync_in` 0→1 held 10 cycles → `busy` high for 3 cycles, `clean_out`=1 from edge 4, `rise_pulse` high for exactly one cycle.
- Glitch: `sync_in` high for 3 cycles then 0 → `clean_out` stays 0, no pulse, `busy` returns to 0 one edge after `sync_in` drops.
- Bounce: `sync_in` sequence 1,0,1,1,1,1 → qualification restarts and `clean_out` rises after edge 6. Release from high with 4 cycles of 0 → single `fall_pulse`, `clean_out`=0.
- Mid-qualification reset: `n_rst` pulsed low during QUAL_HIGH at `qcnt`=2 → outputs 0 immediately. Re-qualification then takes the full 4 cycles.
- With `DEBOUNCE_EVENT_CNT_EN`, CNT_WIDTH=8:
  - 300 accepted presses → `event_count`=255.
  - `clear` asserted in the same cycle as `rise_pulse` → `event_count`=0.
